// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates the CPU fetch (if_*) and data (d_*) request channels onto
//          one single-port word memory; one transaction in flight at a time.
// Latency: accept c0, memory strobe c1, capture end of c(1+MEM_LAT), response c(2+MEM_LAT).
// Backpressure: request ready only in IDLE; response held stable until rsp_ready.
//
// Ports:
//   clk, rst                   single clock, asynchronous active-low reset
//   if_req_* / if_rsp_*        fetch request (addr) and response (data) channels
//   d_req_* / d_rsp_*          data request (addr, we, wdata) and response channels
//   mem_addr/wdata/wren/rren/E memory command port; mem_rdata memory read data
//   busy                       high whenever the sequencer is not idle
module mem_port_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   // fetch channel
   input  logic        if_req_valid,
   output logic        if_req_ready,
   input  logic [29:0] if_addr,
   output logic        if_rsp_valid,
   input  logic        if_rsp_ready,
   output logic [31:0] if_rsp_data,
   // data channel
   input  logic        d_req_valid,
   output logic        d_req_ready,
   input  logic [29:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   output logic        d_rsp_valid,
   input  logic        d_rsp_ready,
   output logic [31:0] d_rsp_data,
   // memory port
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wren,
   output logic        mem_rren,
   output logic        mem_E,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [29:0]   r_addr;
   logic [31:0]   r_wdata;
   logic          r_we;
   logic          r_ch_if;       // 1 = transaction belongs to the fetch channel
   logic [LW-1:0] r_wait_cnt;
   logic [SW-1:0] r_starve;
   logic [31:0]   r_if_rsp_data;
   logic [31:0]   r_d_rsp_data;

   logic          w_idle;
   logic          w_force_if;
   logic          w_grant_if;
   logic          w_grant_d;
   logic          w_accept;
   logic          w_capture;
   logic [31:0]   w_cap_data;

   assign w_idle = (r_state == S_IDLE);

   // Fetch overrides the default data priority once data has been granted
   // STARVE_MAX times in a row while fetch was waiting.
   assign w_force_if = if_req_valid && (r_starve == SW'(STARVE_MAX));

   // Grants include the request valid, so a grant is also the handshake.
   // rst gates the grants so both readies are low while reset is asserted,
   // even though the state register already reads IDLE.
   assign w_grant_if = rst && w_idle && if_req_valid && (w_force_if || !d_req_valid);
   assign w_grant_d  = rst && w_idle && d_req_valid && !w_force_if;
   assign w_accept   = w_grant_if || w_grant_d;

   assign if_req_ready = w_grant_if;
   assign d_req_ready  = w_grant_d;

   // Last WAIT cycle is ISSUE+MEM_LAT; stores return a zero ack word.
   assign w_capture  = (r_state == S_WAIT) && (r_wait_cnt == '0);
   assign w_cap_data = r_we ? 32'h0 : mem_rdata;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next state and decoded outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      mem_E        = 1'b0;
      mem_wren     = 1'b0;
      mem_rren     = 1'b0;
      if_rsp_valid = 1'b0;
      d_rsp_valid  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            mem_E       = 1'b1;
            mem_wren    = r_we;
            mem_rren    = ~r_we;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_capture) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if_rsp_valid = r_ch_if;
            d_rsp_valid  = ~r_ch_if;
            if (r_ch_if ? if_rsp_ready : d_rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request capture. The address register drives mem_addr directly and is
   // only reloaded on accept, so it stays stable from ISSUE through capture
   // (the memory keeps reading while E is low).
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_ch_if <= 1'b0;
      end else if (w_accept) begin
         r_addr  <= w_grant_if ? if_addr : d_addr;
         r_wdata <= w_grant_if ? 32'h0 : d_wdata;
         r_we    <= w_grant_d & d_we;
         r_ch_if <= w_grant_if;
      end
   end

   // ------------------------------------------------------------------
   // Memory latency counter: loaded in ISSUE, counts down through WAIT.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wait_cnt <= LW'(MEM_LAT - 1);
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
         r_wait_cnt <= r_wait_cnt - LW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Starvation counter: only evaluated in IDLE, where grants happen.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= '0;
      end else if (w_idle) begin
         if (!if_req_valid || w_grant_if) begin
            r_starve <= '0;
         end else if (w_grant_d && (r_starve != SW'(STARVE_MAX))) begin
            r_starve <= r_starve + SW'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-channel response data registers; held until the next capture
   // for the same channel.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_if_rsp_data <= '0;
         r_d_rsp_data  <= '0;
      end else if (w_capture) begin
         if (r_ch_if) begin
            r_if_rsp_data <= w_cap_data;
         end else begin
            r_d_rsp_data  <= w_cap_data;
         end
      end
   end

   assign if_rsp_data = r_if_rsp_data;
   assign d_rsp_data  = r_d_rsp_data;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign busy        = !w_idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter with a behavioural
//          single-port memory and a transaction-level reference model.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
module tb_mem_port_arbiter;

   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready;
   logic [29:0] if_addr;
   logic [31:0] if_rsp_data;
   logic        d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_ready;
   logic [29:0] d_addr;
   logic [31:0] d_wdata, d_rsp_data;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_wren, mem_rren, mem_E, busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
      .d_we(d_we), .d_wdata(d_wdata),
      .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
      .mem_rren(mem_rren), .mem_E(mem_E), .mem_rdata(mem_rdata), .busy(busy)
   );

   // Behavioural synchronous memory: reads every cycle (one-cycle latency),
   // writes when E & wren. Preload/clear ports are bench-only.
   logic [31:0] phys [0:1023];
   logic        mem_clr = 1'b0;
   logic        pl_en = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 1024; i++) phys[i] = 32'h0;
      end else begin
         mem_rdata <= phys[mem_addr[9:0]];
         if (pl_en) phys[pl_addr] = pl_data;
         if (mem_E && mem_wren) phys[mem_addr[9:0]] = mem_wdata;
      end
   end

   // Reference memory contents as the bench expects them.
   logic [31:0] ref_mem [0:1023];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d_send(input logic [29:0] a, input logic we, input logic [31:0] wd,
                         output int waited);
      d_req_valid = 1'b1; d_addr = a; d_we = we; d_wdata = wd; waited = 0;
      @(negedge clk);
      while (!d_req_ready && waited < 50) begin
         tick(); waited++; @(negedge clk);
      end
      if (!d_req_ready) waited = -1;
      tick();
      d_req_valid = 1'b0;
   endtask

   task automatic if_send(input logic [29:0] a, output int waited);
      if_req_valid = 1'b1; if_addr = a; waited = 0;
      @(negedge clk);
      while (!if_req_ready && waited < 50) begin
         tick(); waited++; @(negedge clk);
      end
      if (!if_req_ready) waited = -1;
      tick();
      if_req_valid = 1'b0;
   endtask

   // Called one cycle after accept; returns the cycle index of rsp_valid
   // (accept cycle = 0) and leaves the bench at that cycle's negedge.
   task automatic wait_rsp(input bit fetch, output int cyc, output logic [31:0] dat);
      cyc = 1;
      @(negedge clk);
      while (!(fetch ? if_rsp_valid : d_rsp_valid) && cyc < 50) begin
         tick(); cyc++; @(negedge clk);
      end
      if (!(fetch ? if_rsp_valid : d_rsp_valid)) cyc = -1;
      dat = fetch ? if_rsp_data : d_rsp_data;
   endtask

   task automatic test_reset();
      rst = 1'b0; mem_clr = 1'b1;
      if_req_valid = 1'b1; if_addr = 30'h40; if_rsp_ready = 1'b1;
      d_req_valid = 1'b1; d_addr = 30'h100; d_we = 1'b0; d_wdata = '0; d_rsp_ready = 1'b1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
      repeat (3) tick();
      mem_clr = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_wren, mem_rren, mem_E, busy} !== 8'h0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b required 00000000",
                  {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_wren, mem_rren, mem_E, busy});
      end
      n_vec++;
      if ({mem_addr, mem_wdata, if_rsp_data, d_rsp_data} !== '0) begin
         n_err++;
         $display("FAIL reset_data: addr %h wdata %h ifd %h dd %h required all 0",
                  mem_addr, mem_wdata, if_rsp_data, d_rsp_data);
      end
      tick();
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: busy %b ifr %b dr %b required 0 0 0", busy, if_req_ready, d_req_ready);
      end
      tick();
   endtask

   task automatic test_load();
      pl_en = 1'b1; pl_addr = 10'h40; pl_data = 32'hDEADBEEF;
      ref_mem[10'h40] = 32'hDEADBEEF;
      tick();
      pl_en = 1'b0;
      d_rsp_ready = 1'b1; d_req_valid = 1'b1; d_addr = 30'h40; d_we = 1'b0;
      @(negedge clk);
      n_vec++;
      if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL load_accept: dr %b ifr %b required 1 0", d_req_ready, if_req_ready);
      end
      tick();
      d_req_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({mem_E, mem_rren, mem_wren, busy} !== 4'b1101 || mem_addr !== 30'h40) begin
         n_err++;
         $display("FAIL load_issue: E/rren/wren/busy %b addr %h required 1101 addr 40",
                  {mem_E, mem_rren, mem_wren, busy}, mem_addr);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (mem_E !== 1'b0 || d_rsp_valid !== 1'b0 || mem_addr !== 30'h40) begin
         n_err++;
         $display("FAIL load_wait: E %b rspv %b addr %h required 0 0 40", mem_E, d_rsp_valid, mem_addr);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL load_resp_c3: rspv %b data %h required 1 deadbeef", d_rsp_valid, d_rsp_data);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || d_rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL load_idle: busy %b rspv %b required 0 0", busy, d_rsp_valid);
      end
      tick();
   endtask

   task automatic test_store_load();
      int w, c;
      logic [31:0] dat;
      d_rsp_ready = 1'b1;
      d_send(30'h100, 1'b1, 32'h64, w);
      ref_mem[10'h100] = 32'h64;
      wait_rsp(1'b0, c, dat);
      n_vec++;
      if (w !== 0 || c !== 3 || dat !== 32'h0) begin
         n_err++;
         $display("FAIL store_ack: wait %0d cyc %0d data %h required 0 3 00000000", w, c, dat);
      end
      tick();
      d_send(30'h100, 1'b0, 32'h0, w);
      wait_rsp(1'b0, c, dat);
      n_vec++;
      if (w !== 0 || c !== 3 || dat !== 32'h64) begin
         n_err++;
         $display("FAIL store_readback: wait %0d cyc %0d data %h required 0 3 00000064", w, c, dat);
      end
      tick();
   endtask

   task automatic test_contention();
      int n, c;
      logic [31:0] dat, got_d;
      if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
      if_req_valid = 1'b1; if_addr = 30'h40;
      d_req_valid = 1'b1; d_addr = 30'h100; d_we = 1'b0;
      got_d = 32'hFFFF_FFFF;
      @(negedge clk);
      n_vec++;
      if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL contention_grant: dr %b ifr %b required 1 0", d_req_ready, if_req_ready);
      end
      tick();
      d_req_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!if_req_ready && n < 20) begin
         if (d_rsp_valid) got_d = d_rsp_data;
         tick(); n++; @(negedge clk);
      end
      n_vec++;
      if (n !== 4 || got_d !== 32'h64) begin
         n_err++;
         $display("FAIL contention_period: fetch grant at cycle %0d d data %h required 4 00000064", n, got_d);
      end
      tick();
      if_req_valid = 1'b0;
      wait_rsp(1'b1, c, dat);
      n_vec++;
      if (c !== 3 || dat !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL contention_fetch: cyc %0d data %h required 3 deadbeef", c, dat);
      end
      tick();
   endtask

   task automatic test_starvation();
      bit got [0:9];
      int ng, c;
      logic [31:0] dat;
      ng = 0;
      if_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
      if_req_valid = 1'b1; if_addr = 30'h40;
      d_req_valid = 1'b1; d_addr = 30'h100; d_we = 1'b0;
      for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
         @(negedge clk);
         if (if_req_ready && d_req_ready) begin
            n_vec++; n_err++;
            $display("FAIL starve_double_grant: ifr 1 dr 1 required one-hot");
         end
         if (if_req_ready) begin got[ng] = 1'b1; ng++; end
         else if (d_req_ready) begin got[ng] = 1'b0; ng++; end
         tick();
      end
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      n_vec++;
      if (ng !== 10) begin
         n_err++;
         $display("FAIL starve_count: %0d grants required 10", ng);
      end
      for (int i = 0; i < ng; i++) begin
         n_vec++;
         if (got[i] !== ((i % 5) == 4)) begin
            n_err++;
            $display("FAIL starve_order[%0d]: fetch=%b required %b", i, got[i], ((i % 5) == 4));
         end
      end
      wait_rsp(1'b1, c, dat);
      n_vec++;
      if (dat !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL starve_last_fetch: data %h required deadbeef", dat);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int w, c;
      logic [31:0] dat;
      if_rsp_ready = 1'b0; d_rsp_ready = 1'b1;
      if_send(30'h40, w);
      wait_rsp(1'b1, c, dat);
      n_vec++;
      if (w !== 0 || c !== 3 || dat !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL bp_first: wait %0d cyc %0d data %h required 0 3 deadbeef", w, c, dat);
      end
      tick();
      d_req_valid = 1'b1; d_addr = 30'h100; d_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'hDEADBEEF || d_req_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: v %b data %h dr %b busy %b required 1 deadbeef 0 1",
                     i, if_rsp_valid, if_rsp_data, d_req_ready, busy);
         end
         tick();
      end
      if_rsp_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (if_rsp_valid !== 1'b1 || d_req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL bp_handshake: v %b dr %b required 1 0", if_rsp_valid, d_req_ready);
      end
      tick();
      @(negedge clk);
      n_vec++;
      if (d_req_ready !== 1'b1 || if_rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bp_next_accept: dr %b v %b required 1 0", d_req_ready, if_rsp_valid);
      end
      tick();
      d_req_valid = 1'b0;
      wait_rsp(1'b0, c, dat);
      n_vec++;
      if (c !== 3 || dat !== 32'h64) begin
         n_err++;
         $display("FAIL bp_d_resp: cyc %0d data %h required 3 00000064", c, dat);
      end
      tick();
   endtask

   task automatic test_reset_midwait();
      int w, c;
      logic [31:0] dat;
      d_rsp_ready = 1'b1; if_rsp_ready = 1'b1;
      d_send(30'h40, 1'b0, 32'h0, w);
      tick();
      if_req_valid = 1'b1; if_addr = 30'h100;
      #1 rst = 1'b0;
      #1;
      n_vec++;
      if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_wren, mem_rren, mem_E, busy} !== 8'h0 ||
          {mem_addr, mem_wdata, if_rsp_data, d_rsp_data} !== '0) begin
         n_err++;
         $display("FAIL midwait_reset: ctrl %b addr %h wdata %h ifd %h dd %h required all 0",
                  {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_wren, mem_rren, mem_E, busy},
                  mem_addr, mem_wdata, if_rsp_data, d_rsp_data);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || if_req_ready !== 1'b1 || d_rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midwait_idle: busy %b ifr %b drspv %b required 0 1 0", busy, if_req_ready, d_rsp_valid);
      end
      tick();
      if_req_valid = 1'b0;
      wait_rsp(1'b1, c, dat);
      n_vec++;
      if (c !== 3 || dat !== 32'h64 || d_rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL midwait_after: cyc %0d data %h drspv %b required 3 00000064 0", c, dat, d_rsp_valid);
      end
      tick();
   endtask

   // Randomised traffic checked against a transaction-level model: grant
   // priority with starvation override, fixed 3-cycle response latency,
   // response held until consumed, memory contents tracked in ref_mem.
   task automatic test_random();
      bit m_busy, m_ch, e_if, e_d, e_rv_if, e_rv_d, rsp_hs;
      int age, mcnt, n_txn;
      logic [31:0] m_exp, obs;
      m_busy = 0; m_ch = 0; age = 0; mcnt = 0; n_txn = 0; m_exp = '0;
      if_req_valid = 1'b0; d_req_valid = 1'b0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         @(negedge clk);
         if (m_busy) age++;
         e_rv_if = m_busy && m_ch && (age >= 3);
         e_rv_d  = m_busy && !m_ch && (age >= 3);
         n_vec++;
         if (if_rsp_valid !== e_rv_if || d_rsp_valid !== e_rv_d || busy !== m_busy) begin
            n_err++;
            $display("FAIL rand_state@%0d: ifv %b dv %b busy %b required %b %b %b",
                     cyc, if_rsp_valid, d_rsp_valid, busy, e_rv_if, e_rv_d, m_busy);
         end
         if (e_rv_if || e_rv_d) begin
            obs = m_ch ? if_rsp_data : d_rsp_data;
            n_vec++;
            if (obs !== m_exp) begin
               n_err++;
               $display("FAIL rand_data@%0d: got %h required %h", cyc, obs, m_exp);
            end
         end
         rsp_hs = (e_rv_if && if_rsp_ready) || (e_rv_d && d_rsp_ready);
         e_if = 0; e_d = 0;
         if (!m_busy) begin
            if (if_req_valid && (mcnt == STARVE || !d_req_valid)) e_if = 1;
            else if (d_req_valid) e_d = 1;
            if (!if_req_valid || e_if) mcnt = 0;
            else if (e_d && mcnt < STARVE) mcnt++;
         end
         n_vec++;
         if (if_req_ready !== e_if || d_req_ready !== e_d) begin
            n_err++;
            $display("FAIL rand_grant@%0d: ifr %b dr %b required %b %b", cyc, if_req_ready, d_req_ready, e_if, e_d);
         end
         if (e_if) begin
            m_busy = 1; age = 0; m_ch = 1; m_exp = ref_mem[if_addr[9:0]]; n_txn++;
         end else if (e_d) begin
            m_busy = 1; age = 0; m_ch = 0; n_txn++;
            m_exp = d_we ? 32'h0 : ref_mem[d_addr[9:0]];
            if (d_we) ref_mem[d_addr[9:0]] = d_wdata;
         end
         if (rsp_hs) m_busy = 0;
         tick();
         if (e_if) if_req_valid = 1'b0;
         if (e_d) d_req_valid = 1'b0;
         if (cyc < 600) begin
            if (!if_req_valid && $urandom_range(0, 2) == 0) begin
               if_req_valid = 1'b1;
               if_addr = 30'h200 + 30'($urandom_range(0, 15));
            end
            if (!d_req_valid && $urandom_range(0, 1) == 0) begin
               d_req_valid = 1'b1;
               d_addr  = 30'h200 + 30'($urandom_range(0, 15));
               d_we    = 1'($urandom_range(0, 1));
               d_wdata = $urandom;
            end
            if_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready  = ($urandom_range(0, 3) != 0);
         end else begin
            if_rsp_ready = 1'b1;
            d_rsp_ready  = 1'b1;
         end
      end
      n_vec++;
      if (m_busy || if_req_valid || d_req_valid || n_txn < 30) begin
         n_err++;
         $display("FAIL rand_drain: busy %b ifv %b dv %b txns %0d required 0 0 0 >=30",
                  m_busy, if_req_valid, d_req_valid, n_txn);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_load();
      test_contention();
      test_starvation();
      test_backpressure();
      test_reset_midwait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
